ps2_key_decoder: RTL and testbench

Turns the raw PS/2 byte stream from the keyboard receiver into discrete key events: make/break, extended flag, scan code. Sits between the PS/2 byte receiver and the cursor/ENTER/ESC control logic in the top level. That logic then consumes one clean event per keystroke instead of inspecting multi-byte scan sequences itself. Events are buffered in a small FIFO with a valid/ready handshake.

---
 rtl/ps2_key_decoder.sv | 98 +++++++++
 tb/tb_ps2_key_decoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 scan-byte parser feeding a show-ahead key-event FIFO.
// Define PS2_TYPEMATIC_FILTER_EN to suppress typematic auto-repeat makes.
module ps2_key_decoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 250000
) (
   input  logic       clk50,
   input  logic       RST,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_break,
   output logic       ovf,
   input  logic       ovf_clr
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;
   state_t        state;
   logic [2:0]    skip;
   logic [TW-1:0] tcnt;
   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rp, wp;
   logic [AW:0]   cnt;
   logic          junk, tout, ev_push, push, pop, full, wr;
   logic [9:0]    ev_data;
   assign junk = byte_in inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
   assign tout = state != IDLE && !byte_valid && tcnt == TW'(TIMEOUT - 1);
   assign ev_push = byte_valid && (
      (state == IDLE && !junk && !(byte_in inside {8'hE0, 8'hF0, 8'hE1})) ||
      (state == EXT && byte_in != 8'hF0) || state == BRK || state == EXT_BRK);
   assign ev_data = {byte_in, state == EXT || state == EXT_BRK, state == BRK || state == EXT_BRK};
`ifdef PS2_TYPEMATIC_FILTER_EN
   logic [8:0] held_key;
   logic       held;
   assign push = ev_push && !(held && !ev_data[0] && held_key == ev_data[9:1]);
   always_ff @(posedge clk50 or negedge RST)
      if (!RST) begin
         held     <= 1'b0;
         held_key <= '0;
      end else if (ev_push) begin
         if (!ev_data[0]) begin
            held     <= 1'b1;
            held_key <= ev_data[9:1];
         end else if (held_key == ev_data[9:1]) held <= 1'b0;
      end
`else
   assign push = ev_push;
`endif
   always_ff @(posedge clk50 or negedge RST)
      if (!RST) begin
         state <= IDLE;
         skip  <= '0;
         tcnt  <= '0;
      end else begin
         tcnt <= (state == IDLE || byte_valid) ? '0 : tcnt + TW'(1);
         if (tout) state <= IDLE;
         else if (byte_valid)
            case (state)
               IDLE:
                  if (byte_in == 8'hE0) state <= EXT;
                  else if (byte_in == 8'hF0) state <= BRK;
                  else if (byte_in == 8'hE1) begin
                     skip  <= 3'd7;
                     state <= SKIP;
                  end
               EXT:          state <= byte_in == 8'hF0 ? EXT_BRK : IDLE;
               BRK, EXT_BRK: state <= IDLE;
               default: begin
                  skip <= skip - 3'd1;
                  if (skip == 3'd1) state <= IDLE;
               end
            endcase
      end
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign pop  = ev_valid && ev_ready;
   assign full = cnt == (AW+1)'(FIFO_DEPTH);
   assign wr   = push && (!full || pop);
   always_ff @(posedge clk50 or negedge RST)
      if (!RST) begin
         rp  <= '0;
         wp  <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         rp  <= rp + AW'(pop);
         wp  <= wp + AW'(wr);
         cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
         ovf <= (push && full && !pop) || (ovf && !ovf_clr);
      end
   always_ff @(posedge clk50)
      if (wr) mem[wp] <= ev_data;
   assign ev_valid = cnt != '0;
   assign {ev_code, ev_ext, ev_break} = ev_valid ? mem[rp] : 10'd0;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed and random byte streams checked against a
// sequence-level reference model of the decoder and its event FIFO.
module tb_ps2_key_decoder;
   localparam int DEPTH = 4;
   localparam int TO    = 20;
`ifdef PS2_TYPEMATIC_FILTER_EN
   localparam int FILT_N = 2;
`else
   localparam int FILT_N = 4;
`endif
   logic       clk50 = 1'b0, RST = 1'b0, byte_valid = 1'b0, ev_ready = 1'b0, ovf_clr = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic       ev_valid, ev_ext, ev_break, ovf;
   logic [7:0] ev_code;
   int         checks = 0, errors = 0;
   logic [9:0] exp_q [$];
   bit         m_ext, m_brk, m_ovf, m_held;
   logic [8:0] m_hk;
   int         m_skip, m_gap;
   logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h00,
                             8'h14, 8'h77, 8'h1D, 8'h5A, 8'h75, 8'h6B};

   ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
      .clk50(clk50), .RST(RST), .byte_in(byte_in), .byte_valid(byte_valid),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
      .ev_break(ev_break), .ovf(ovf), .ovf_clr(ovf_clr));

   always #5 clk50 = ~clk50;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_emit(input logic [7:0] b);
      logic [9:0] e;
      e = {b, m_ext, m_brk};
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (!m_brk) begin
         if (m_held && m_hk == {b, m_ext}) return;
         m_held = 1;
         m_hk = {b, m_ext};
      end else if (m_hk == {b, m_ext}) m_held = 0;
`endif
      if (exp_q.size() < DEPTH) exp_q.push_back(e);
      else m_ovf = 1;
   endtask

   task automatic m_byte(input logic [7:0] b);
      if ((m_ext || m_brk || m_skip > 0) && m_gap >= TO) begin
         m_ext = 0; m_brk = 0; m_skip = 0;
      end
      m_gap = 0;
      if (m_skip > 0) m_skip--;
      else if (!m_ext && !m_brk && b == 8'hE1) m_skip = 7;
      else if (!m_ext && !m_brk && b == 8'hE0) m_ext = 1;
      else if (!m_brk && b == 8'hF0) m_brk = 1;
      else begin
         if (m_ext || m_brk || !(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) m_emit(b);
         m_ext = 0; m_brk = 0;
      end
   endtask

   task automatic cycle(input bit bv, input logic [7:0] b, input bit rdy, input bit clr = 0);
      bit popped;
      check("ev_valid", ev_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("head", {ev_code, ev_ext, ev_break}, exp_q[0]);
      popped = rdy && exp_q.size() != 0;
      byte_valid = bv; byte_in = b; ev_ready = rdy; ovf_clr = clr;
      @(posedge clk50); #1;
      byte_valid = 0; ovf_clr = 0;
      if (popped) void'(exp_q.pop_front());
      if (clr) m_ovf = 0;
      if (bv) m_byte(b);
      else m_gap++;
      check("ovf", ovf, m_ovf);
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1, b, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 8'h00, 0);
   endtask

   task automatic drain(output int n);
      n = 0;
      for (int i = 0; i < 2 * DEPTH + 2 && (ev_valid || exp_q.size() != 0); i++) begin
         if (ev_valid) n++;
         cycle(0, 8'h00, 1);
      end
      check("drained", ev_valid, 0);
   endtask

   task automatic do_reset;
      RST = 0; #1;
      check("rst_valid", ev_valid, 0);
      check("rst_event", {ev_code, ev_ext, ev_break}, 0);
      check("rst_ovf", ovf, 0);
      @(posedge clk50); #1;
      RST = 1;
      exp_q.delete();
      m_ext = 0; m_brk = 0; m_skip = 0; m_gap = 0; m_ovf = 0; m_held = 0; m_hk = '0;
   endtask

   initial begin
      int n;
      logic [7:0] c;
      do_reset();
      send(8'h1D);
      check("latency", ev_valid, 1);
      check("first_make", {ev_code, ev_ext, ev_break}, {8'h1D, 2'b00});
      send(8'hF0); send(8'h1D);
      drain(n);
      check("make_break_n", n, 2);
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      send(8'hAA); send(8'hFA);
      check("ext_make", {ev_code, ev_ext, ev_break}, {8'h75, 2'b10});
      drain(n);
      check("ext_n", n, 2);
      foreach (pool[i]) if (i < 0) c = 0;
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0);
      send(8'h14); send(8'hF0); send(8'h77);
      check("pause_none", ev_valid, 0);
      send(8'h5A);
      check("after_pause", {ev_code, ev_ext, ev_break}, {8'h5A, 2'b00});
      drain(n);
      send(8'hE0); idle(TO - 1); send(8'h1C);
      check("to_edge_cont", {ev_code, ev_ext, ev_break}, {8'h1C, 2'b10});
      drain(n);
      send(8'hE0); idle(TO); send(8'h1C);
      check("to_fired", {ev_code, ev_ext, ev_break}, {8'h1C, 2'b00});
      drain(n);
      c = 8'($urandom_range(1, 8'h60));
      for (int i = 0; i < DEPTH + 1; i++) send(c + 8'(i));
      check("ovf_set", ovf, 1);
      drain(n);
      check("ovf_kept_n", n, DEPTH);
      cycle(0, 8'h00, 0, 1);
      check("ovf_clr", ovf, 0);
      for (int i = 0; i < DEPTH; i++) send(c + 8'(i + 8));
      cycle(1, c + 8'h20, 1);
      check("full_pushpop", ovf, 0);
      drain(n);
      check("full_pushpop_n", n, DEPTH);
      for (int i = 0; i < DEPTH; i++) send(c + 8'(i + 1));
      cycle(1, c + 8'h30, 0, 1);
      check("set_wins", ovf, 1);
      drain(n);
      cycle(0, 8'h00, 0, 1);
      do_reset();
      send(8'h1D); send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D);
      drain(n);
      check("typematic_n", n, FILT_N);
      send(8'h33); send(8'h34); send(8'hF0);
      do_reset();
      send(8'h23);
      check("post_rst", {ev_code, ev_ext, ev_break}, {8'h23, 2'b00});
      drain(n);
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r >= 97) for (int k = 0; k < TO - 1 + int'($urandom_range(0, 2)); k++)
            cycle(0, 8'h00, 1'($urandom_range(0, 1)));
         else begin
            c = r < 90 ? pool[$urandom_range(0, 11)] : 8'($urandom);
            cycle(r < 60, c, 1'($urandom_range(0, 1)), r == 50);
         end
      end
      drain(n);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
